uart_word_packer: RTL and testbench

Parametrised successor to the UART FSM byte-holding register. It collects bytes received by the UART FSM and packs NUM_BYTES of them into one wide word for the DDR3 write-data path. It replaces the single enabled byte register with:
- an assembly stage,
- a one-word output register with a valid/ready handshake,
- a partial-word flush,
- byte-order selection and drop detection.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_word_oreg.sv | 32 +++
 rtl/uart_word_packer.sv | 71 +++++++
 tb/tb_uart_word_packer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and helpers for the UART byte-to-word packer
package uart_pkg;
    localparam int D_WIDTH_DEF = 8;
    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST_ENC = 1'b1;
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/uart_word_oreg.sv
// uart_word_oreg: one-word output register with valid/ready hold and free indication
module uart_word_oreg #(
    parameter int W  = 128,
    parameter int CW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_word,
    input  logic [CW-1:0] i_count,
    input  logic          i_ready,
    output logic [W-1:0]  o_word,
    output logic [CW-1:0] o_count,
    output logic          o_valid,
    output logic          o_free
);
    assign o_free = ~o_valid | i_ready;
    // capture a completed word when free, otherwise hold until the handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_word  <= '0;
            o_count <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_word  <= i_word;
            o_count <= i_count;
            o_valid <= 1'b1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs UART bytes into wide words with flush, backpressure and drop detection
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int NUM_BYTES = 16,
    parameter bit MSB_FIRST = LSB_FIRST,
    parameter int CW        = count_width(NUM_BYTES)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [D_WIDTH-1:0]             i_data,
    input  logic                           i_enable,
    input  logic                           i_flush,
    output logic                           o_byte_ready,
    output logic [D_WIDTH*NUM_BYTES-1:0]   o_word,
    output logic [CW-1:0]                  o_count,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_drop
);
    localparam int W = D_WIDTH * NUM_BYTES;
    logic [W-1:0]  asm_q, asm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending, take, complete, load, free;
    assign take = i_enable & ~pending;
    assign o_byte_ready = ~pending;
    // place the accepted byte into the lane selected by the byte order
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q + CW'(take);
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (take && cnt_q == CW'((MSB_FIRST == MSB_FIRST_ENC) ? NUM_BYTES - 1 - k : k))
                asm_d[k*D_WIDTH +: D_WIDTH] = i_data;
        end
    end
    assign complete = ~pending & ((cnt_d == CW'(NUM_BYTES)) | (i_flush & (cnt_d != '0)));
    assign load = (pending | complete) & free;
    // assembly buffer, byte counter, pending flag and drop pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            pending <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= i_enable & pending;
            if (load) begin
                asm_q   <= '0;
                cnt_q   <= '0;
                pending <= 1'b0;
            end else begin
                asm_q   <= asm_d;
                cnt_q   <= cnt_d;
                pending <= pending | complete;
            end
        end
    end
    uart_word_oreg #(.W(W), .CW(CW)) u_oreg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_word  (asm_d),
        .i_count (cnt_d),
        .i_ready (i_ready),
        .o_word  (o_word),
        .o_count (o_count),
        .o_valid (o_valid),
        .o_free  (free)
    );
endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed and randomized checks of both byte orders against a queue model
module tb_uart_word_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  d = '0;
    logic        en = 1'b0, fl = 1'b0, rdy = 1'b0;
    logic        br0, br1, v0, v1, dr0, dr1;
    logic [31:0] w0, w1;
    logic [2:0]  c0, c1;
    int checks = 0, fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_word_packer #(.D_WIDTH(8), .NUM_BYTES(4), .MSB_FIRST(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_data(d), .i_enable(en), .i_flush(fl),
        .o_byte_ready(br0), .o_word(w0), .o_count(c0), .o_valid(v0),
        .i_ready(rdy), .o_drop(dr0));
    uart_word_packer #(.D_WIDTH(8), .NUM_BYTES(4), .MSB_FIRST(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_data(d), .i_enable(en), .i_flush(fl),
        .o_byte_ready(br1), .o_word(w1), .o_count(c1), .o_valid(v1),
        .i_ready(rdy), .o_drop(dr1));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // behavioural model: list of bytes in the word being assembled, one output slot
    logic [7:0]  mbytes[$];
    bit          mpend, mvalid, mdrop;
    logic [31:0] mw0, mw1;
    int          mcount;

    function automatic logic [31:0] pack(input logic [7:0] b[$], input bit msb);
        logic [31:0] w = '0;
        foreach (b[k]) w[(msb ? 3 - k : k)*8 +: 8] = b[k];
        return w;
    endfunction

    always @(posedge clk) begin
        bit free, done;
        if (!rst_n) begin
            mbytes.delete();
            mpend = 0; mvalid = 0; mdrop = 0; mw0 = '0; mw1 = '0; mcount = 0;
        end else begin
            free = !mvalid || rdy;
            mdrop = en && mpend;
            if (en && !mpend) mbytes.push_back(d);
            done = mpend || mbytes.size() == 4 || (fl && mbytes.size() > 0);
            if (done && free) begin
                mw0 = pack(mbytes, 1'b0);
                mw1 = pack(mbytes, 1'b1);
                mcount = mbytes.size();
                mvalid = 1;
                mpend = 0;
                mbytes.delete();
            end else begin
                if (done) mpend = 1;
                if (mvalid && rdy) mvalid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid0", 32'(v0), 32'(mvalid));
            chk("valid1", 32'(v1), 32'(mvalid));
            chk("word0", w0, mw0);
            chk("word1", w1, mw1);
            chk("count0", 32'(c0), 32'(mcount));
            chk("count1", 32'(c1), 32'(mcount));
            chk("bready0", 32'(br0), 32'(!mpend));
            chk("bready1", 32'(br1), 32'(!mpend));
            chk("drop0", 32'(dr0), 32'(mdrop));
            chk("drop1", 32'(dr1), 32'(mdrop));
        end
    end

    task automatic drv(input bit r, input bit e, input bit f, input bit rd, input logic [7:0] b);
        @(posedge clk);
        #1;
        rst_n = r; en = e; fl = f; rdy = rd; d = b;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        // reset
        drv(0, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 0);
        drv(1, 0, 0, 1, 0);
        chk_on = 1'b1;
        samp();
        chk("rst_valid", 32'(v0), 0);
        chk("rst_word", w0, 0);
        chk("rst_count", 32'(c0), 0);
        chk("rst_drop", 32'(dr0), 0);
        chk("rst_bready", 32'(br0), 1);
        // both byte orders, full rate
        for (int i = 0; i < 4; i++) drv(1, 1, 0, 1, seq[i]);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("lsb_word", w0, 32'h44332211);
        chk("msb_word", w1, 32'h11223344);
        chk("lsb_count", 32'(c0), 4);
        chk("lsb_valid", 32'(v0), 1);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("lsb_valid_one_cycle", 32'(v0), 0);
        // backpressure, pending word and drop
        for (int i = 0; i < 8; i++) drv(1, 1, 0, 0, seq[i]);
        drv(1, 1, 0, 0, 8'h99);
        samp();
        chk("bp_bready", 32'(br0), 0);
        chk("bp_hold_word", w0, 32'h44332211);
        chk("bp_hold_valid", 32'(v0), 1);
        drv(1, 0, 0, 0, 0);
        samp();
        chk("bp_drop", 32'(dr0), 1);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("bp_drop_pulse", 32'(dr0), 0);
        chk("bp_first", w0, 32'h44332211);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("bp_second", w0, 32'h88776655);
        chk("bp_second_valid", 32'(v0), 1);
        chk("bp_bready_back", 32'(br0), 1);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("bp_idle_valid", 32'(v0), 0);
        chk("bp_keep_word", w0, 32'h88776655);
        // flush
        drv(1, 1, 0, 1, 8'hAA);
        drv(1, 1, 0, 1, 8'hBB);
        drv(1, 0, 1, 1, 0);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("fl_word", w0, 32'h0000BBAA);
        chk("fl_word_msb", w1, 32'hAABB0000);
        chk("fl_count", 32'(c0), 2);
        drv(1, 1, 1, 1, 8'hCC);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("flb_word", w0, 32'h000000CC);
        chk("flb_count", 32'(c0), 1);
        chk("flb_valid", 32'(v0), 1);
        drv(1, 0, 1, 1, 0);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("fl_empty_valid", 32'(v0), 0);
        // reset mid-operation
        for (int i = 4; i < 8; i++) drv(1, 1, 0, 0, seq[i]);
        drv(1, 1, 0, 0, 8'h10);
        drv(1, 1, 0, 0, 8'h20);
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 1, 0);
        samp();
        chk("mr_valid", 32'(v0), 0);
        chk("mr_word", w0, 0);
        chk("mr_count", 32'(c0), 0);
        chk("mr_bready", 32'(br0), 1);
        for (int i = 1; i <= 4; i++) drv(1, 1, 0, 1, 8'(i));
        drv(1, 0, 0, 1, 0);
        samp();
        chk("mr_word_after", w0, 32'h04030201);
        chk("mr_count_after", 32'(c0), 4);
        // randomized traffic
        for (int i = 0; i < 4000; i++)
            drv($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
        drv(1, 0, 0, 1, 0);
        samp();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
